// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants for the instruction fetch stage: instruction
//               field widths, field slice positions, the reset fetch address
//               and helpers that split an instruction byte into its fields.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int OPCODE_W   = 3;
    localparam int IMM_W      = 5;
    localparam int INSTR_W    = 8;

    // Opcode occupies the top bits of the byte, immediate the bottom bits.
    localparam int OPCODE_LSB = 5;
    localparam int IMM_LSB    = 0;

    localparam int RESET_PC   = 0;

    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] b);
        return b[OPCODE_LSB +: OPCODE_W];
    endfunction

    function automatic logic [IMM_W-1:0] get_immediate(input logic [INSTR_W-1:0] b);
        return b[IMM_LSB +: IMM_W];
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Ring-buffer prefetch queue with push, pop and flush.
//               DEPTH must be a power of two so the pointers wrap naturally.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               push, wdata       - write wdata at the tail
//               pop               - advance the head
//               flush             - discard all entries (pointers to 0)
//               rdata             - head entry (valid content only if !empty)
//               count/full/empty  - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] c_depth = DEPTH[PW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only the bookkeeping is discarded.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch stage. Requests bytes from memory at the
//               fetch PC, buffers them in a prefetch queue and presents the
//               head byte split into opcode/immediate with its fetch address.
//               A redirect flushes the queue and restarts fetch.
// Ports       : clk, reset                  - clock, sync active-high reset
//               mem_req/mem_addr            - fetch request and address
//               mem_ack/mem_data            - request accepted, byte returned
//               redirect/redirect_addr      - branch flush and new fetch PC
//               instr_valid/instr_ready     - head handshake to consumer
//               opcode/immediate/instr_pc   - head instruction fields
// Config      : FETCH_QUEUE_BYPASS_EN - when defined, an acked byte arriving
//               at an empty queue is presented to the consumer in the same
//               cycle (consumed without a push if instr_ready is high).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req,
    output logic [AW-1:0]        mem_addr,
    input  logic                 mem_ack,
    input  logic [INSTR_W-1:0]   mem_data,
    input  logic                 redirect,
    input  logic [AW-1:0]        redirect_addr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [IMM_W-1:0]     immediate,
    output logic [AW-1:0]        instr_pc
);

    localparam int EW = INSTR_W + AW;

    logic [AW-1:0]            r_fetch_pc;
    logic [EW-1:0]            w_rdata;
    logic [EW-1:0]            w_head;
    logic [INSTR_W-1:0]       w_head_byte;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_fifo_push;
    logic                     w_fifo_pop;

    // Request only when there is guaranteed room; a same-cycle pop does not
    // count, so no speculative request is ever raised at full.
    assign mem_req  = !reset && !redirect && !w_full;
    assign mem_addr = r_fetch_pc;

    // mem_req already excludes redirect, so redirect-cycle ack data is dropped.
    assign w_push = mem_req && mem_ack;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;

    assign w_bypass    = w_empty && w_push;
    assign w_head      = w_bypass ? {mem_data, r_fetch_pc} : w_rdata;
    assign instr_valid = ((w_count != '0) && !redirect) || w_bypass;
    // A bypassed byte that the consumer takes immediately never enters the ring.
    assign w_fifo_push = w_push && !(w_bypass && instr_ready);
    assign w_fifo_pop  = instr_valid && instr_ready && !w_empty;
`else
    assign w_head      = w_rdata;
    assign instr_valid = (w_count != '0) && !redirect;
    assign w_fifo_push = w_push;
    assign w_fifo_pop  = instr_valid && instr_ready && !w_empty;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= AW'(RESET_PC);
        end else if (redirect) begin
            r_fetch_pc <= redirect_addr;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .flush (redirect),
        .wdata ({mem_data, r_fetch_pc}),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_head_byte = w_head[EW-1:AW];
    assign opcode      = get_opcode(w_head_byte);
    assign immediate   = get_immediate(w_head_byte);
    assign instr_pc    = w_head[AW-1:0];

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A queue-based reference
//               model predicts request, address and head outputs each cycle
//               for directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [7:0]    mem_data;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    opcode;
    logic [4:0]    immediate;
    logic [AW-1:0] instr_pc;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .opcode        (opcode),
        .immediate     (immediate),
        .instr_pc      (instr_pc)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: instruction memory, pending entries {byte, pc}, fetch PC.
    logic [7:0]  mem [256];
    logic [15:0] q [$];
    logic [7:0]  m_pc;

    // Last sampled DUT outputs, for scenario-specific checks.
    logic        o_req, o_valid;
    logic [7:0]  o_addr, o_pc;
    logic [2:0]  o_op;
    logic [4:0]  o_imm;

    logic [15:0] seen [$];
    int          nv;

    task automatic step(input bit r, input bit rd, input logic [7:0] ra,
                        input bit ack, input bit rdy, input bit chk_en);
        bit          e_req, byp, e_valid, pop, push;
        logic [15:0] e_head;
        @(negedge clk);
        reset         = r;
        redirect      = rd;
        redirect_addr = ra;
        mem_ack       = ack;
        instr_ready   = rdy;
        mem_data      = mem[m_pc];
        #1;
        e_req = !r && !rd && (q.size() < DEPTH);
        byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp   = (q.size() == 0) && ack && e_req;
`endif
        e_valid = ((q.size() != 0) && !rd) || byp;
        if (byp)               e_head = {mem[m_pc], m_pc};
        else if (q.size() != 0) e_head = q[0];
        else                   e_head = 16'h0;
        o_req = mem_req; o_addr = mem_addr; o_valid = instr_valid;
        o_op = opcode; o_imm = immediate; o_pc = instr_pc;
        if (chk_en) begin
            check("mem_req", o_req, e_req);
            check("mem_addr", o_addr, m_pc);
            check("instr_valid", o_valid, e_valid);
            if (e_valid) begin
                check("opcode", o_op, e_head[15:13]);
                check("immediate", o_imm, e_head[12:8]);
                check("instr_pc", o_pc, e_head[7:0]);
            end
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_pc = 8'h00;
        end else if (rd) begin
            q.delete();
            m_pc = ra;
        end else begin
            pop  = e_valid && rdy;
            push = e_req && ack;
            if (byp && rdy) begin
                m_pc = m_pc + 8'h01;
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back({mem[m_pc], m_pc});
                    m_pc = m_pc + 8'h01;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h25;
        mem[1] = 8'hE3;
        m_pc = 8'h00;
        reset = 1'b1; redirect = 1'b0; redirect_addr = '0;
        mem_ack = 1'b0; instr_ready = 1'b0; mem_data = '0;

        // Initial reset; outputs are unknown before it takes effect.
        step(1, 0, 8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);
        check("rst_opcode", o_op, 3'd0);
        check("rst_imm", o_imm, 5'd0);
        check("rst_pc", o_pc, 8'd0);

        // Streaming: continuous ack, consumer always ready.
        seen.delete(); nv = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 8'h00, 1, 1, 1);
            if (o_valid) begin seen.push_back({o_op, o_imm, o_pc}); nv++; end
        end
        check("stream_n", seen.size() >= 2, 1);
        if (seen.size() >= 2) begin
            check("stream_i0", seen[0], {3'b001, 5'b00101, 8'h00});
            check("stream_i1", seen[1], {3'b111, 5'b00011, 8'h01});
        end
        check("stream_rate", nv >= 5, 1);

        // Fill to full, then release one slot.
        step(1, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0, 1);
        step(0, 0, 8'h00, 1, 0, 1);
        check("full_req", o_req, 1'b0);
        check("full_addr", o_addr, 8'h04);
        step(0, 0, 8'h00, 1, 1, 1);
        step(0, 0, 8'h00, 1, 0, 1);
        check("refill_req", o_req, 1'b1);
        check("refill_addr", o_addr, 8'h04);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 0, 1, 1);

        // Redirect with three entries queued and a same-cycle ack.
        step(1, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0, 1);
        step(0, 1, 8'h40, 1, 1, 1);
        check("redir_valid", o_valid, 1'b0);
        step(0, 0, 8'h00, 0, 1, 1);
        check("redir_req", o_req, 1'b1);
        check("redir_addr", o_addr, 8'h40);
        check("redir_empty", o_valid, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 1, 1);

        // Address wrap after redirect to the top of memory.
        step(0, 1, 8'hFF, 0, 1, 1);
        seen.delete();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 8'h00, 1, 1, 1);
            if (o_valid) seen.push_back({8'h00, o_pc});
        end
        check("wrap_n", seen.size() >= 3, 1);
        if (seen.size() >= 3) begin
            check("wrap_pc0", seen[0], 16'h00FF);
            check("wrap_pc1", seen[1], 16'h0000);
            check("wrap_pc2", seen[2], 16'h0001);
        end

        // Reset wins over a simultaneous redirect on a full queue.
        step(1, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0, 1);
        step(1, 1, 8'h40, 1, 1, 1);
        step(0, 0, 8'h00, 0, 0, 1);
        check("rr_valid", o_valid, 1'b0);
        check("rr_addr", o_addr, 8'h00);
        check("rr_opcode", o_op, 3'd0);
        check("rr_imm", o_imm, 5'd0);
        check("rr_pc", o_pc, 8'd0);

        // Ack into an empty queue with the consumer ready.
        mem[0] = 8'hE3;
        step(0, 0, 8'h00, 1, 1, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid", o_valid, 1'b1);
        check("byp_opcode", o_op, 3'b111);
        step(0, 0, 8'h00, 0, 0, 1);
        check("byp_count0", o_valid, 1'b0);
`else
        check("nobyp_valid0", o_valid, 1'b0);
        step(0, 0, 8'h00, 0, 0, 1);
        check("nobyp_valid1", o_valid, 1'b1);
        check("nobyp_opcode", o_op, 3'b111);
        check("nobyp_pc", o_pc, 8'h00);
`endif

        // Randomized traffic with varying ack/ready densities.
        for (int b = 0; b < 6; b++) begin
            int ack_pct, rdy_pct;
            ack_pct = $urandom_range(20, 100);
            rdy_pct = $urandom_range(10, 100);
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4, 8'($urandom),
                     $urandom_range(0, 99) < ack_pct, $urandom_range(0, 99) < rdy_pct, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
